dither_frame_sequencer: RTL and testbench

//  Parametrised frame sequencer for the dithering accelerator; generalises the fixed 64x64 gray load/compute/read flow.

---
 rtl/dither_frame_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_dither_frame_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dither_frame_sequencer.sv
// Frame sequencer for the dithering accelerator.
// Loads a frame of interleaved channel samples into the frame RAM. Kicks
// the compute unit and guards it with a watchdog. Then streams the processed
// frame back out in the same order it was loaded.
module dither_frame_sequencer #(
  parameter int IMAGEX           = 64,
  parameter int IMAGEY           = 64,
  parameter int CHANNELS         = 1,
  parameter int RGB_SIZE         = 8,
  parameter int IMAGE_ADDR_WIDTH = (IMAGEX * IMAGEY > 1) ? $clog2(IMAGEX * IMAGEY) : 1,
  parameter int CH_W             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int TIMEOUT_CYCLES   = 1000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic [RGB_SIZE-1:0]         in_data,
  output logic                        in_ready,
  output logic                        ram_we,
  output logic [IMAGE_ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [CH_W-1:0]             ram_wr_ch,
  output logic [RGB_SIZE-1:0]         ram_wr_data,
  output logic                        compute_start,
  input  logic                        compute_done,
  output logic                        ram_rd_en,
  output logic [IMAGE_ADDR_WIDTH-1:0] ram_rd_addr,
  output logic [CH_W-1:0]             ram_rd_ch,
  input  logic [RGB_SIZE-1:0]         ram_rd_data,
  output logic                        out_valid,
  output logic [RGB_SIZE-1:0]         out_data,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        error
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_PIX  = IMAGE_ADDR_WIDTH'(IMAGEX * IMAGEY - 1);
  localparam logic [CH_W-1:0]             LAST_CH   = CH_W'(CHANNELS - 1);
  localparam logic [TMR_W-1:0]            TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_OUT,
    S_ERROR
  } state_t;

  state_t                        state_q, state_d;
  logic [IMAGE_ADDR_WIDTH-1:0]   pix_q, pix_d;
  logic [CH_W-1:0]               ch_q, ch_d;
  logic [TMR_W-1:0]              tmr_q, tmr_d;
  logic [RGB_SIZE-1:0]           out_data_q, out_data_d;
  logic                          compute_start_q, compute_start_d;
  logic                          frame_done_q, frame_done_d;

  // Position bookkeeping shared by the load and read-back walks
  logic                          ch_wrap;
  logic                          last_sample;
  logic [CH_W-1:0]               ch_adv;
  logic [IMAGE_ADDR_WIDTH-1:0]   pix_adv;

  // Next channel/pixel position: channels wrap first, then the pixel advances
  always_comb begin
    ch_wrap     = (ch_q == LAST_CH);
    last_sample = ch_wrap && (pix_q == LAST_PIX);
    ch_adv      = ch_wrap ? '0 : ch_q + 1'b1;
    pix_adv     = ch_wrap ? pix_q + 1'b1 : pix_q;
  end

  // State, counters and registered pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      pix_q           <= '0;
      ch_q            <= '0;
      tmr_q           <= '0;
      out_data_q      <= '0;
      compute_start_q <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      pix_q           <= pix_d;
      ch_q            <= ch_d;
      tmr_q           <= tmr_d;
      out_data_q      <= out_data_d;
      compute_start_q <= compute_start_d;
      frame_done_q    <= frame_done_d;
    end
  end

  // Next-state logic and the per-state combinational strobes
  always_comb begin
    state_d         = state_q;
    pix_d           = pix_q;
    ch_d            = ch_q;
    tmr_d           = tmr_q;
    out_data_d      = out_data_q;
    compute_start_d = 1'b0;
    frame_done_d    = 1'b0;
    in_ready        = 1'b0;
    ram_we          = 1'b0;
    ram_wr_addr     = '0;
    ram_wr_ch       = '0;
    ram_wr_data     = '0;
    ram_rd_en       = 1'b0;
    ram_rd_addr     = '0;
    ram_rd_ch       = '0;
    out_valid       = 1'b0;
    busy            = 1'b1;
    error           = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_LOAD;
          pix_d   = '0;
          ch_d    = '0;
          tmr_d   = '0;
        end
      end

      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ram_we      = 1'b1;
          ram_wr_addr = pix_q;
          ram_wr_ch   = ch_q;
          ram_wr_data = in_data;
          if (last_sample) begin
            // Frame complete: rewind counters for the read-back walk
            state_d         = S_COMPUTE;
            pix_d           = '0;
            ch_d            = '0;
            tmr_d           = '0;
            compute_start_d = 1'b1;
          end else begin
            pix_d = pix_adv;
            ch_d  = ch_adv;
          end
        end
      end

      S_COMPUTE: begin
        tmr_d = tmr_q + 1'b1;
        // A completion arriving on the expiry cycle still counts as success
        if (compute_done) begin
          state_d = S_RD_REQ;
        end else if (tmr_d == TMR_LIMIT) begin
          state_d = S_ERROR;
        end
      end

      S_RD_REQ: begin
        ram_rd_en   = 1'b1;
        ram_rd_addr = pix_q;
        ram_rd_ch   = ch_q;
        state_d     = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        // RAM data is valid the cycle after the read strobe
        out_data_d = ram_rd_data;
        state_d    = S_RD_OUT;
      end

      S_RD_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (last_sample) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
            pix_d        = '0;
            ch_d         = '0;
          end else begin
            state_d = S_RD_REQ;
            pix_d   = pix_adv;
            ch_d    = ch_adv;
          end
        end
      end

      S_ERROR: begin
        busy  = 1'b0;
        error = 1'b1;
        if (start) begin
          state_d = S_LOAD;
          pix_d   = '0;
          ch_d    = '0;
          tmr_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign compute_start = compute_start_q;
  assign frame_done    = frame_done_q;
  assign out_data      = out_data_q;

endmodule

// File: tb/tb_dither_frame_sequencer.sv
// Randomized bench for dither_frame_sequencer: a 4x2 RGB frame with a short watchdog.
// The reference is simple: sample i of a frame lives at pixel i/CH, channel i%CH.
// The frame must come back unchanged and in the same order.
`timescale 1ns/1ps
module tb_dither_frame_sequencer;

  localparam int IX   = 4;
  localparam int IY   = 2;
  localparam int CH   = 3;
  localparam int RS   = 8;
  localparam int TO   = 10;
  localparam int NPIX = IX * IY;
  localparam int N    = NPIX * CH;
  localparam int AW   = $clog2(NPIX);
  localparam int CW   = $clog2(CH);

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [RS-1:0] in_data;
  logic          in_ready;
  logic          ram_we;
  logic [AW-1:0] ram_wr_addr;
  logic [CW-1:0] ram_wr_ch;
  logic [RS-1:0] ram_wr_data;
  logic          compute_start;
  logic          compute_done;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [CW-1:0] ram_rd_ch;
  logic [RS-1:0] ram_rd_data;
  logic          out_valid;
  logic [RS-1:0] out_data;
  logic          out_ready;
  logic          busy;
  logic          frame_done;
  logic          error;

  dither_frame_sequencer #(
    .IMAGEX(IX), .IMAGEY(IY), .CHANNELS(CH), .RGB_SIZE(RS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_wr_ch(ram_wr_ch), .ram_wr_data(ram_wr_data),
    .compute_start(compute_start), .compute_done(compute_done),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_ch(ram_rd_ch), .ram_rd_data(ram_rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .frame_done(frame_done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame RAM stand-in: compute leaves the frame untouched, read has one cycle latency
  logic [RS-1:0] mem [0:N-1];
  always @(posedge clk) begin
    if (ram_we) mem[int'(ram_wr_addr) * CH + int'(ram_wr_ch)] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[int'(ram_rd_addr) * CH + int'(ram_rd_ch)];
  end

  int checks   = 0;
  int failures = 0;
  logic [RS-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Feed n samples with random gaps and stray start pulses; check each write
  task automatic do_load(input int n);
    int i;
    i = 0;
    exp_q = {};
    while (i < n) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = RS'($urandom);
      start    = ($urandom_range(0, 5) == 0);
      #1;
      chk("in_ready", 32'(in_ready), 32'd1);
      chk("ram_we", 32'(ram_we), 32'(in_valid));
      if (in_valid) begin
        chk("wr_addr", 32'(ram_wr_addr), 32'(i / CH));
        chk("wr_ch", 32'(ram_wr_ch), 32'(i % CH));
        chk("wr_data", 32'(ram_wr_data), 32'(in_data));
        exp_q.push_back(in_data);
        i++;
      end
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // d = COMPUTE cycle (1..TO) on which compute_done is raised; 0 = never
  task automatic do_compute(input int d);
    for (int k = 1; k <= TO; k++) begin
      in_valid     = $urandom_range(0, 1) == 1;
      in_data      = RS'($urandom);
      compute_done = (k == d);
      #1;
      chk("cstart", 32'(compute_start), 32'(k == 1));
      chk("cmp_busy", 32'(busy), 32'd1);
      chk("cmp_error", 32'(error), 32'd0);
      chk("cmp_in_ready", 32'(in_ready), 32'd0);
      chk("cmp_ram_we", 32'(ram_we), 32'd0);
      tick();
      compute_done = 1'b0;
      if (k == d) break;
    end
    in_valid = 1'b0;
    if (d == 0) begin
      chk("to_error", 32'(error), 32'd1);
      chk("to_busy", 32'(busy), 32'd0);
      chk("to_out_valid", 32'(out_valid), 32'd0);
      chk("to_in_ready", 32'(in_ready), 32'd0);
    end else begin
      chk("done_error", 32'(error), 32'd0);
      chk("rd_en_first", 32'(ram_rd_en), 32'd1);
      chk("rd_addr_first", 32'(ram_rd_addr), 32'd0);
      chk("cstart_once", 32'(compute_start), 32'd0);
    end
  endtask

  // mode 0: always ready, 1: ready toggles every 2 cycles, 2: random ready
  task automatic do_read(input int mode, input int stop_at);
    int j;
    int cyc;
    bit stall;
    logic [RS-1:0] held;
    j     = 0;
    cyc   = 0;
    stall = 1'b0;
    held  = '0;
    while (j < stop_at && cyc < 20 * N) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc / 2) % 2) == 0;
        default: out_ready = $urandom_range(0, 1) == 1;
      endcase
      #1;
      chk("fd_early", 32'(frame_done), 32'd0);
      if (stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(held));
      end
      stall = 1'b0;
      if (out_valid && out_ready) begin
        chk("out_data", 32'(out_data), 32'(exp_q[j]));
        j++;
        tick();
        cyc++;
        if (j == N) begin
          out_ready = 1'b0;
          chk("frame_done", 32'(frame_done), 32'd1);
          chk("done_busy", 32'(busy), 32'd0);
          chk("done_out_valid", 32'(out_valid), 32'd0);
          tick();
          chk("frame_done_clr", 32'(frame_done), 32'd0);
        end else begin
          chk("out_gap", 32'(out_valid), 32'd0);
        end
      end else begin
        if (out_valid) begin
          stall = 1'b1;
          held  = out_data;
        end
        tick();
        cyc++;
      end
    end
    out_ready = 1'b0;
    if (j < stop_at) chk("rd_timeout", 32'(j), 32'(stop_at));
  endtask

  task automatic full_frame(input int d, input int mode);
    do_start();
    do_load(N);
    do_compute(d);
    do_read(mode, N);
    $display("frame: done_at=%0d ready_mode=%0d samples=%0d", d, mode, N);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    compute_done = 1'b0;
    out_ready    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cstart", 32'(compute_start), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
    tick();

    // Input and compute_done while idle are ignored
    in_valid     = 1'b1;
    compute_done = 1'b1;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_ram_we", 32'(ram_we), 32'd0);
    tick();
    in_valid     = 1'b0;
    compute_done = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic frame, backpressure, done exactly on watchdog expiry
    full_frame(5, 0);
    full_frame(1, 1);
    full_frame(TO, 2);

    // Watchdog expiry, then recovery through start
    do_start();
    do_load(N);
    do_compute(0);
    compute_done = 1'b1;
    in_valid     = 1'b1;
    #1;
    chk("err_ram_we", 32'(ram_we), 32'd0);
    tick();
    compute_done = 1'b0;
    in_valid     = 1'b0;
    chk("err_sticky", 32'(error), 32'd1);
    do_start();
    chk("err_exit_error", 32'(error), 32'd0);
    chk("err_exit_busy", 32'(busy), 32'd1);
    chk("err_exit_in_ready", 32'(in_ready), 32'd1);
    do_load(N);
    do_compute(4);
    do_read(2, N);
    $display("frame: watchdog expiry then recovery, samples=%0d", N);

    // Reset after 7 samples, then a fresh frame must restart at address 0
    do_start();
    do_load(7);
    in_valid = 1'b1;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mid_ram_we", 32'(ram_we), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    tick();
    full_frame(2, 1);

    // Reset during read-back: no outputs and no frame_done afterwards
    do_start();
    do_load(N);
    do_compute(3);
    do_read(0, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("rrst_frame_done", 32'(frame_done), 32'd0);
      chk("rrst_out_valid", 32'(out_valid), 32'd0);
      chk("rrst_rd_en", 32'(ram_rd_en), 32'd0);
      chk("rrst_busy", 32'(busy), 32'd0);
      tick();
    end
    $display("frame: reset during read-back after 5 samples");

    // A few fully random frames
    for (int f = 0; f < 3; f++) begin
      full_frame(int'($urandom_range(1, TO)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
